key_events: RTL and testbench

- Input-side front end for the game logic: turns raw active-low pushbuttons into clean, frame-aligned key events.
- Synchronizes and debounces each KEY line.
- Emits one-cycle press/release pulses and a held level.
- Accumulates presses between frame ticks so game logic that samples only on `frame` never misses a short press.
- Sits between the board KEY pins and the game state machine, sharing its clock and frame strobe.

---
 rtl/key_events_if.sv | 22 ++
 rtl/key_events.sv | 124 ++++++++++++
 tb/tb_key_events.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/key_events_if.sv
// Key front-end bundle: frame strobe and raw KEY lines in, debounced key events out.
// "released" carries the release pulse; "release" is a reserved word in SystemVerilog.
interface key_events_if #(
  parameter int NKEYS = 4
);
  logic             frame;
  logic [NKEYS-1:0] KEY;
  logic [NKEYS-1:0] held;
  logic [NKEYS-1:0] press;
  logic [NKEYS-1:0] released;
  logic [NKEYS-1:0] frame_press;

  modport master (
    output frame, KEY,
    input  held, press, released, frame_press
  );

  modport slave (
    input  frame, KEY,
    output held, press, released, frame_press
  );
endinterface

// File: rtl/key_events.sv
// Pushbutton front end: sync + debounce per key, press/release pulses, per-frame press latch.
// Optional auto-repeat into frame_press when KEY_REPEAT_EN is defined.
module key_events #(
  parameter int NKEYS           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
`ifdef KEY_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 30,
  parameter int REPEAT_RATE     = 6
`endif
) (
  input  logic         clk,
  input  logic         rst,
  key_events_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NKEYS-1:0] held_q;
  logic [NKEYS-1:0] press_q;
  logic [NKEYS-1:0] rel_q;
  logic [NKEYS-1:0] rep_fire;
  logic [NKEYS-1:0] acc_reg;
  logic [NKEYS-1:0] frame_press_reg;

  generate
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
      logic             sync1_reg;
      logic             sync2_reg;
      logic             held_reg;
      logic             press_reg;
      logic             rel_reg;
      logic [CNT_W-1:0] cnt_reg;

      // Synchronizer holds pressed polarity so reset means "not pressed".
      always_ff @(posedge clk) begin
        if (rst) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
          held_reg  <= 1'b0;
          press_reg <= 1'b0;
          rel_reg   <= 1'b0;
          cnt_reg   <= '0;
        end else begin
          sync1_reg <= ~bus.KEY[gi];
          sync2_reg <= sync1_reg;
          press_reg <= 1'b0;
          rel_reg   <= 1'b0;
          if (sync2_reg == held_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            held_reg  <= ~held_reg;
            press_reg <= ~held_reg;
            rel_reg   <= held_reg;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      end

      assign held_q[gi]  = held_reg;
      assign press_q[gi] = press_reg;
      assign rel_q[gi]   = rel_reg;
    end
  endgenerate

`ifdef KEY_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = (REP_MAX < 2) ? 1 : $clog2(REP_MAX + 1);

  generate
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_rep
      logic          armed_reg;
      logic [RW-1:0] dcnt_reg;
      logic [RW-1:0] rcnt_reg;
      logic          due;

      // Before arming, count to the initial delay; afterwards count the repeat period.
      assign due = armed_reg ? (rcnt_reg == RW'(REPEAT_RATE - 1))
                             : (dcnt_reg == RW'(REPEAT_DELAY - 1));
      assign rep_fire[gi] = bus.frame & held_q[gi] & due;

      always_ff @(posedge clk) begin
        if (rst || !held_q[gi]) begin
          armed_reg <= 1'b0;
          dcnt_reg  <= '0;
          rcnt_reg  <= '0;
        end else if (bus.frame) begin
          if (!armed_reg) begin
            if (due) armed_reg <= 1'b1;
            else     dcnt_reg  <= dcnt_reg + 1'b1;
          end else begin
            if (due) rcnt_reg <= '0;
            else     rcnt_reg <= rcnt_reg + 1'b1;
          end
        end
      end
    end
  endgenerate
`else
  assign rep_fire = '0;
`endif

  // A press landing on the frame cycle belongs to the interval being closed.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg         <= '0;
      frame_press_reg <= '0;
    end else if (bus.frame) begin
      frame_press_reg <= acc_reg | press_q | rep_fire;
      acc_reg         <= '0;
    end else begin
      acc_reg <= acc_reg | press_q;
    end
  end

  assign bus.held        = held_q;
  assign bus.press       = press_q;
  assign bus.released    = rel_q;
  assign bus.frame_press = frame_press_reg;

endmodule

// File: tb/tb_key_events.sv
// Directed scoreboard bench for key_events with DEBOUNCE_CYCLES=4.
// With KEY_REPEAT_EN defined it also checks auto-repeat (delay 3, rate 2).
module tb_key_events;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  key_events_if #(.NKEYS(4)) bus();

  key_events #(
    .NKEYS(4),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3)
`ifdef KEY_REPEAT_EN
    ,
    .REPEAT_DELAY(3),
    .REPEAT_RATE(2)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    string      tag;
    logic [3:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [3:0] v);
    exp_t e;
    e.tag = tag;
    e.exp = v;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [3:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%b expected=<none>", obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.exp);
    end
  endtask

  task automatic pulse_frame();
    bus.frame = 1'b1;
    tick(1);
    bus.frame = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    bus.KEY   = 4'hF;
    bus.frame = 1'b0;
    tick(2);
    rst = 1'b0;

    // Reset state
    push("rst_held", 4'b0000);  pop_check(bus.held);
    push("rst_press", 4'b0000); pop_check(bus.press);
    push("rst_rel", 4'b0000);   pop_check(bus.released);
    push("rst_fp", 4'b0000);    pop_check(bus.frame_press);
    for (int i = 0; i < 20; i++) begin
      push($sformatf("idle_%0d", i), 4'b0000);
      tick(1);
      pop_check(bus.held | bus.press | bus.released | bus.frame_press);
    end
    $display("txn reset: outputs idle");

    // Clean press of key 0
    bus.KEY[0] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      push($sformatf("press0_held_e%0d", e), 4'(e >= 6));
      push($sformatf("press0_pulse_e%0d", e), 4'(e == 6));
    end
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      pop_check(bus.held);
      pop_check(bus.press);
    end
    $display("txn press key0");

    // Clean release of key 0
    bus.KEY[0] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      push($sformatf("rel0_held_e%0d", e), 4'(e < 6));
      push($sformatf("rel0_pulse_e%0d", e), 4'(e == 6));
    end
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      pop_check(bus.held);
      pop_check(bus.released);
    end
    $display("txn release key0");

    // Bounce on key 1
    bus.KEY[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push($sformatf("bounce1_low_%0d", i), 4'b0000);
      tick(1);
      pop_check(bus.held);
    end
    bus.KEY[1] = 1'b1;
    push("bounce1_high", 4'b0000);
    tick(1);
    pop_check(bus.held);
    bus.KEY[1] = 1'b0;
    for (int e = 1; e <= 7; e++) begin
      push($sformatf("bounce1_held_e%0d", e), (e >= 6) ? 4'b0010 : 4'b0000);
      push($sformatf("bounce1_pulse_e%0d", e), (e == 6) ? 4'b0010 : 4'b0000);
    end
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      pop_check(bus.held);
      pop_check(bus.press);
    end
    bus.KEY[1] = 1'b1;
    tick(8);
    push("flush_keys01", 4'b0011);
    pulse_frame();
    pop_check(bus.frame_press);
    $display("txn bounce key1");

    // Frame latch for key 2
    push("fp_empty", 4'b0000);
    pulse_frame();
    pop_check(bus.frame_press);
    bus.KEY[2] = 1'b0;
    tick(8);
    push("fp_key2", 4'b0100);
    pulse_frame();
    pop_check(bus.frame_press);
    for (int i = 0; i < 5; i++) begin
      push($sformatf("fp_key2_hold_%0d", i), 4'b0100);
      tick(1);
      pop_check(bus.frame_press);
    end
    push("fp_key2_next", 4'b0000);
    pulse_frame();
    pop_check(bus.frame_press);
    bus.KEY[2] = 1'b1;
    tick(8);
    $display("txn frame latch key2");

    // Press coincident with frame on key 3
    bus.KEY[3] = 1'b0;
    push("coinc_press3", 4'b1000);
    tick(6);
    pop_check(bus.press);
    bus.frame = 1'b1;
    push("coinc_fp", 4'b1000);
    tick(1);
    bus.frame = 1'b0;
    pop_check(bus.frame_press);
    bus.KEY[3] = 1'b1;
    tick(3);
    push("coinc_next", 4'b0000);
    pulse_frame();
    pop_check(bus.frame_press);
    tick(8);
    $display("txn coincident press key3");

    // Frame held high continuously: frame_press tracks press one cycle later
    bus.frame  = 1'b1;
    bus.KEY[0] = 1'b0;
    for (int e = 1; e <= 8; e++) push($sformatf("contframe_e%0d", e), 4'(e == 7));
    for (int e = 1; e <= 8; e++) begin
      tick(1);
      pop_check(bus.frame_press);
    end
    bus.frame  = 1'b0;
    bus.KEY[0] = 1'b1;
    tick(8);
    $display("txn continuous frame key0");

    // Reset in the middle of a debounce
    bus.KEY[0] = 1'b0;
    tick(4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    push("midrst_held", 4'b0000);
    pop_check(bus.held);
    for (int e = 1; e <= 7; e++) push($sformatf("midrst_pulse_e%0d", e), 4'(e == 6));
    for (int e = 1; e <= 7; e++) begin
      tick(1);
      pop_check(bus.press);
    end
    bus.KEY[0] = 1'b1;
    tick(8);
    push("midrst_flush", 4'b0001);
    pulse_frame();
    pop_check(bus.frame_press);
    $display("txn reset mid-debounce key0");

`ifdef KEY_REPEAT_EN
    // Auto-repeat on key 0 across 9 held frames
    bus.KEY[0] = 1'b0;
    tick(8);
    for (int n = 1; n <= 9; n++) begin
      push($sformatf("repeat_f%0d", n), 4'((n == 1) || (n >= 3 && (n % 2) == 1)));
      tick(2);
      pulse_frame();
      pop_check(bus.frame_press);
    end
    bus.KEY[0] = 1'b1;
    tick(8);
    $display("txn auto-repeat key0");
`endif

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
